mem_line_requester: RTL
=======================

Name: mem_line_requester

Overview:
Initiator-side counterpart of the line memory (MEM_core). It accepts single-word read/write requests from a CPU stage over a valid/ready handshake and turns them into line-granular memory requests. Each word write is carried out as a read-modify-write of the whole line. Memory responses are matched by echoed line address, a per-request timeout raises an error, and exactly one CPU response pulse is returned per accepted request.

Parameters:
WORD_WIDTH, 32, CPU word / instruction width
WORDS_PER_LINE, 4, words per memory line; power of two, at least 2
LINE_WIDTH, WORD_WIDTH*WORDS_PER_LINE, memory line width
ADDR_WIDTH, 32, CPU word-address width
TIMEOUT, 15, maximum RD_WAIT cycles before an error response; at least 2

Ports:
clock  in  1  single clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = in reset)
cpu_req_valid  in  1  CPU request present
cpu_req_write  in  1  1 = word write, 0 = word read
cpu_req_addr  in  ADDR_WIDTH  word address
cpu_req_wdata  in  WORD_WIDTH  write data
cpu_req_ready  out  1  requester can accept a request
cpu_resp_valid  out  1  one-cycle completion pulse
cpu_resp_rdata  out  WORD_WIDTH  read data; 0 for writes and errors
cpu_resp_error  out  1  request timed out
mem_req_read  out  1  line read request
mem_req_write  out  1  line write request
mem_req_addr  out  ADDR_WIDTH  line address
mem_req_data  out  LINE_WIDTH  line write data
mem_resp_valid  in  1  memory response valid
mem_resp_addr  in  ADDR_WIDTH  echoed line address
mem_resp_data  in  LINE_WIDTH  line data; word 0 in bits [WORD_WIDTH-1:0]

Behaviour:
- Address split: line = cpu_req_addr >> log2(WORDS_PER_LINE); word index = low log2(WORDS_PER_LINE) bits.
- Reset state: state=IDLE, counter=0.
  - Every registered output is 0.
  - cpu_req_ready is 0 while reset is asserted.
  - Reset asserted in any state aborts the operation immediately: no mem_req_write, no cpu_resp_valid.
- cpu_req_ready = (state == IDLE). A request is accepted on a rising edge with cpu_req_valid && cpu_req_ready; addr, write and wdata are latched then.
- All mem_* and cpu_resp_* outputs are registered.
- State machine (IDLE, RD_WAIT, WR, DONE):
  - IDLE: on accept -> RD_WAIT; mem_req_read=1, mem_req_addr=latched line, counter=0.
  - RD_WAIT:
    - mem_req_read held 1; counter increments every cycle.
    - mem_resp_valid is ignored in the first RD_WAIT cycle (stale response).
    - From the second cycle, a response matches when mem_resp_valid && mem_resp_addr == latched line.
    - Responses with a mismatched address are ignored.
    - Match on a read: capture the selected word; -> DONE, mem_req_read=0.
    - Match on a write: capture mem_resp_data with the selected word replaced by wdata; -> WR, mem_req_read=0.
    - If the counter reaches TIMEOUT with no match: -> DONE with error=1, rdata=0, no write. A match in the same cycle as the timeout takes priority.
  - WR: mem_req_write=1 and mem_req_data=merged line for exactly one cycle; mem_req_addr unchanged; -> DONE.
  - DONE: cpu_resp_valid=1 for one cycle with rdata/error; -> IDLE. rdata and error return to 0 in IDLE.
- Latency with a one-cycle responder, counting from the accept edge as cycle 0:
  - mem_req_read in cycle 1; response seen in cycle 2.
  - Read: cpu_resp_valid in cycle 3.
  - Write: mem_req_write in cycle 3, cpu_resp_valid in cycle 4.
- Throughput: one outstanding request. cpu_req_valid outside IDLE is not accepted; the CPU holds it.
- mem_req_read and mem_req_write are never asserted together.

Test Plan:
1. Reset:
   - Hold reset=0 for 2 cycles -> all outputs 0, cpu_req_ready=0.
   - Release -> cpu_req_ready=1; mem_req_read and mem_req_write stay 0 with no request.
2. Read:
   - Stimulus: bench responder has line 1 = 128'h00000007_00000006_00000005_00000004; read addr 0x5.
   - Cycle 1: mem_req_read=1, mem_req_addr=1.
   - Cycle 3: cpu_resp_valid=1, rdata=0x00000005, error=0, for exactly one cycle.
3. Write:
   - Stimulus: write addr 0x6, wdata 0xDEADBEEF.
   - Cycle 3: mem_req_write=1, addr=1, data=128'h00000007_DEADBEEF_00000005_00000004.
   - Cycle 4: cpu_resp_valid=1 with rdata=0.
   - A following read of 0x6 returns 0xDEADBEEF.
4. Address filtering:
   - Stimulus: responder answers with addr 2 for 3 cycles, then addr 1.
   - Mismatched responses are ignored.
   - cpu_resp_valid follows one cycle after the matching response, with rdata=0x00000005.
5. Timeout:
   - Stimulus: responder silent, TIMEOUT=15, accept at cycle 0.
   - mem_req_read is high in cycles 1-15.
   - Cycle 16: cpu_resp_valid=1, error=1, rdata=0; mem_req_write never asserts.
6. Reset mid-operation:
   - Stimulus: assert reset during RD_WAIT of a write.
   - mem_req_read drops to 0 immediately (asynchronously); no write and no response are issued.
   - After release, a read of 0x4 completes in 3 cycles with rdata=0x00000004.

Source files
------------

// File: rtl/mem_line_requester.sv
// mem_line_requester: turns single-word CPU reads/writes into line-granular
// memory requests. Writes are done as read-modify-write of the whole line;
// responses are matched on the echoed line address and a per-request timeout
// produces an error response. One outstanding request at a time.
module mem_line_requester #(
    parameter int WORD_WIDTH     = 32,
    parameter int WORDS_PER_LINE = 4,
    parameter int LINE_WIDTH     = WORD_WIDTH * WORDS_PER_LINE,
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT        = 15
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  cpu_req_valid,
    input  logic                  cpu_req_write,
    input  logic [ADDR_WIDTH-1:0] cpu_req_addr,
    input  logic [WORD_WIDTH-1:0] cpu_req_wdata,
    output logic                  cpu_req_ready,
    output logic                  cpu_resp_valid,
    output logic [WORD_WIDTH-1:0] cpu_resp_rdata,
    output logic                  cpu_resp_error,
    output logic                  mem_req_read,
    output logic                  mem_req_write,
    output logic [ADDR_WIDTH-1:0] mem_req_addr,
    output logic [LINE_WIDTH-1:0] mem_req_data,
    input  logic                  mem_resp_valid,
    input  logic [ADDR_WIDTH-1:0] mem_resp_addr,
    input  logic [LINE_WIDTH-1:0] mem_resp_data
);

    localparam int IDX_W = $clog2(WORDS_PER_LINE);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, RD_WAIT, WR, DONE} state_t;

    state_t                state_reg;
    logic [CNT_W-1:0]      cnt_reg;
    logic                  write_reg;
    logic [IDX_W-1:0]      idx_reg;
    logic [WORD_WIDTH-1:0] wdata_reg;

    logic [WORD_WIDTH-1:0] resp_words [WORDS_PER_LINE];
    logic [LINE_WIDTH-1:0] merged_line;
    logic                  resp_match;
    logic [ADDR_WIDTH-1:0] req_line;

    // Split the response line into words and build the write-merged line:
    // the addressed word is replaced by the latched write data.
    genvar gi;
    generate
        for (gi = 0; gi < WORDS_PER_LINE; gi++) begin : g_words
            assign resp_words[gi] = mem_resp_data[gi*WORD_WIDTH +: WORD_WIDTH];
            assign merged_line[gi*WORD_WIDTH +: WORD_WIDTH] =
                (idx_reg == IDX_W'(gi)) ? wdata_reg : resp_words[gi];
        end
    endgenerate

    assign req_line = cpu_req_addr >> IDX_W;

    // The first RD_WAIT cycle (counter still 0) may carry a stale response,
    // so matching only starts from the second cycle.
    assign resp_match = (cnt_reg != '0) && mem_resp_valid && (mem_resp_addr == mem_req_addr);

    // Ready only in IDLE and never while reset is held.
    assign cpu_req_ready = (state_reg == IDLE) && reset;

    // Request sequencer: IDLE -> RD_WAIT -> (WR) -> DONE -> IDLE, all outputs registered.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            write_reg      <= 1'b0;
            idx_reg        <= '0;
            wdata_reg      <= '0;
            cpu_resp_valid <= 1'b0;
            cpu_resp_rdata <= '0;
            cpu_resp_error <= 1'b0;
            mem_req_read   <= 1'b0;
            mem_req_write  <= 1'b0;
            mem_req_addr   <= '0;
            mem_req_data   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    cpu_resp_valid <= 1'b0;
                    cpu_resp_rdata <= '0;
                    cpu_resp_error <= 1'b0;
                    if (cpu_req_valid) begin
                        write_reg    <= cpu_req_write;
                        idx_reg      <= cpu_req_addr[IDX_W-1:0];
                        wdata_reg    <= cpu_req_wdata;
                        mem_req_addr <= req_line;
                        mem_req_read <= 1'b1;
                        cnt_reg      <= '0;
                        state_reg    <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    cnt_reg <= cnt_reg + CNT_W'(1);
                    // A match wins over a timeout in the same cycle.
                    if (resp_match) begin
                        mem_req_read <= 1'b0;
                        if (write_reg) begin
                            mem_req_data  <= merged_line;
                            mem_req_write <= 1'b1;
                            state_reg     <= WR;
                        end else begin
                            cpu_resp_rdata <= resp_words[idx_reg];
                            cpu_resp_valid <= 1'b1;
                            state_reg      <= DONE;
                        end
                    end else if (cnt_reg == CNT_W'(TIMEOUT - 1)) begin
                        mem_req_read   <= 1'b0;
                        cpu_resp_valid <= 1'b1;
                        cpu_resp_error <= 1'b1;
                        cpu_resp_rdata <= '0;
                        state_reg      <= DONE;
                    end
                end
                WR: begin
                    mem_req_write  <= 1'b0;
                    mem_req_data   <= '0;
                    cpu_resp_valid <= 1'b1;
                    cpu_resp_rdata <= '0;
                    state_reg      <= DONE;
                end
                DONE: begin
                    cpu_resp_valid <= 1'b0;
                    cpu_resp_rdata <= '0;
                    cpu_resp_error <= 1'b0;
                    state_reg      <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule
